// File: rtl/result_tx_framer_if.sv
// Handshake bundle between the result framer, the ALU result register and the UART transmitter.
// The slave modport is the framer's view; the master modport is the surrounding logic's view.
interface result_tx_framer_if #(
  parameter int unsigned TRAMA_SIZE  = 8,
  parameter int unsigned RESULT_SIZE = 16
);
  logic                   i_valid;
  logic [RESULT_SIZE-1:0] i_result;
  logic                   i_tx_done;
  logic [TRAMA_SIZE-1:0]  o_tx_data;
  logic                   o_tx_start;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_overrun;

  modport slave (
    input  i_valid, i_result, i_tx_done,
    output o_tx_data, o_tx_start, o_busy, o_done, o_overrun
  );

  modport master (
    output i_valid, i_result, i_tx_done,
    input  o_tx_data, o_tx_start, o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/result_tx_framer.sv
// Serialises one result word into TRAMA_SIZE-bit frames for UART TX, least-significant frame first.
// Define RESULT_TX_CHECKSUM_EN to append a trailing XOR-of-all-frames checksum frame.
module result_tx_framer #(
  parameter int unsigned TRAMA_SIZE  = 8,
  parameter int unsigned RESULT_SIZE = 16,
  parameter int unsigned COUNTER_LEN = 5
) (
  input logic               i_clk,
  input logic               i_reset,
  result_tx_framer_if.slave bus
);

  localparam int unsigned NFRAMES = RESULT_SIZE / TRAMA_SIZE;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int unsigned NumFrames = NFRAMES + 1;
  localparam logic [COUNTER_LEN-1:0] DataLastIdx = COUNTER_LEN'(NFRAMES - 1);
`else
  localparam int unsigned NumFrames = NFRAMES;
`endif
  localparam logic [COUNTER_LEN-1:0] LastIdx = COUNTER_LEN'(NumFrames - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone} state_e;

  state_e                 state_q, state_d;
  logic [RESULT_SIZE-1:0] shift_q, shift_d;
  logic [COUNTER_LEN-1:0] cnt_q, cnt_d;
  logic [TRAMA_SIZE-1:0]  tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   last_done;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [TRAMA_SIZE-1:0]  csum_q, csum_d;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    last_done = 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          shift_d = bus.i_result;
          cnt_d   = '0;
          state_d = StStart;
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StStart: state_d = StWaitDone;
      StWaitDone: begin
        if (bus.i_tx_done) begin
          if (cnt_q == LastIdx) begin
            state_d   = StIdle;
            last_done = 1'b1;
          end else begin
            cnt_d   = cnt_q + COUNTER_LEN'(1);
            state_d = StStart;
`ifdef RESULT_TX_CHECKSUM_EN
            csum_d  = csum_q ^ shift_q[TRAMA_SIZE-1:0];
            // After the last data frame the shifter carries the checksum as the next frame
            if (cnt_q == DataLastIdx) shift_d = RESULT_SIZE'(csum_d);
            else                      shift_d = shift_q >> TRAMA_SIZE;
`else
            shift_d = shift_q >> TRAMA_SIZE;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of what the next state implies, so they line up with state_q
  always_comb begin
    tx_start_d = (state_d == StStart);
    busy_d     = (state_d != StIdle);
    done_d     = last_done;
    overrun_d  = bus.i_valid && (state_q != StIdle);
    tx_data_d  = (state_d == StStart) ? shift_d[TRAMA_SIZE-1:0] : tx_data_q;
  end

  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_result_tx_framer.sv
// Directed plus randomized bench for result_tx_framer against a frame-list reference model.
// Honours RESULT_TX_CHECKSUM_EN the same way as the design.
module tb_result_tx_framer;

  localparam int unsigned TS = 8;
  localparam int unsigned RS = 16;
  localparam int unsigned NF = RS / TS;

  logic i_clk;
  logic i_reset;
  int   errors = 0;
  int   checks = 0;

  result_tx_framer_if #(.TRAMA_SIZE(TS), .RESULT_SIZE(RS)) bus ();

  result_tx_framer #(
    .TRAMA_SIZE (TS),
    .RESULT_SIZE(RS),
    .COUNTER_LEN(5)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: list of frames the UART should see for a given word
  task automatic model_frames(input logic [RS-1:0] word, output logic [TS-1:0] fr[$]);
    logic [TS-1:0] x;
    fr = {};
    x  = '0;
    for (int k = 0; k < int'(NF); k++) begin
      fr.push_back(TS'(word >> (k * TS)));
      x ^= TS'(word >> (k * TS));
    end
`ifdef RESULT_TX_CHECKSUM_EN
    fr.push_back(x);
`endif
  endtask

  // Called right after an edge; launches a word unless the caller already drove i_valid.
  // With chain set, i_valid for chain_word is raised in the o_done cycle.
  task automatic run_transfer(input logic [RS-1:0] word, input int delay, input bit inject,
                              input logic [RS-1:0] junk, input bit prelaunched,
                              input bit chain, input logic [RS-1:0] chain_word);
    logic [TS-1:0] fr[$];
    model_frames(word, fr);
    if (!prelaunched) begin
      bus.i_valid  = 1'b1;
      bus.i_result = word;
    end
    step();
    bus.i_valid = 1'b0;
    chk("first_start", 32'(bus.o_tx_start), 32'd1);
    chk("first_data", 32'(bus.o_tx_data), 32'(fr[0]));
    chk("busy_rise", 32'(bus.o_busy), 32'd1);
    for (int k = 0; k < fr.size(); k++) begin
      for (int i = 0; i < delay; i++) begin
        if (inject && k == 0 && i == 1) begin
          bus.i_valid  = 1'b1;
          bus.i_result = junk;
        end
        step();
        bus.i_valid = 1'b0;
        chk("wait_nostart", 32'(bus.o_tx_start), 32'd0);
        chk("wait_hold", 32'(bus.o_tx_data), 32'(fr[k]));
        chk("wait_busy", 32'(bus.o_busy), 32'd1);
        chk("wait_overrun", 32'(bus.o_overrun), (inject && k == 0 && i == 1) ? 32'd1 : 32'd0);
      end
      bus.i_tx_done = 1'b1;
      step();
      bus.i_tx_done = 1'b0;
      if (k == fr.size() - 1) begin
        chk("done_pulse", 32'(bus.o_done), 32'd1);
        chk("done_idle", 32'(bus.o_busy), 32'd0);
        chk("done_nostart", 32'(bus.o_tx_start), 32'd0);
      end else begin
        chk("next_start", 32'(bus.o_tx_start), 32'd1);
        chk("next_data", 32'(bus.o_tx_data), 32'(fr[k+1]));
        chk("next_nodone", 32'(bus.o_done), 32'd0);
      end
    end
    if (chain) begin
      bus.i_valid  = 1'b1;
      bus.i_result = chain_word;
    end else begin
      step();
      chk("done_single", 32'(bus.o_done), 32'd0);
      chk("idle_nostart", 32'(bus.o_tx_start), 32'd0);
    end
  endtask

  initial begin
    logic [RS-1:0] w;
    bus.i_valid   = 1'b0;
    bus.i_result  = '0;
    bus.i_tx_done = 1'b0;
    i_reset       = 1'b0;

    // Reset and idle behaviour
    step();
    chk("rst_data", 32'(bus.o_tx_data), 32'd0);
    chk("rst_start", 32'(bus.o_tx_start), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_overrun", 32'(bus.o_overrun), 32'd0);
    i_reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.i_tx_done = 1'b1;
      step();
      bus.i_tx_done = 1'b0;
      step();
      chk("idle_txdone_start", 32'(bus.o_tx_start), 32'd0);
      chk("idle_txdone_busy", 32'(bus.o_busy), 32'd0);
      chk("idle_txdone_done", 32'(bus.o_done), 32'd0);
    end

    // Basic word, then checksum-style word, then overrun while busy
    run_transfer(16'hBEEF, 10, 1'b0, '0, 1'b0, 1'b0, '0);
    run_transfer(16'h1234, 3, 1'b0, '0, 1'b0, 1'b0, '0);
    run_transfer(16'h5555, 4, 1'b1, 16'hAAAA, 1'b0, 1'b0, '0);

    // Reset while waiting on frame 0
    bus.i_valid  = 1'b1;
    bus.i_result = 16'hC3A5;
    step();
    bus.i_valid = 1'b0;
    step();
    step();
    chk("pre_rst_busy", 32'(bus.o_busy), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_data", 32'(bus.o_tx_data), 32'd0);
    chk("arst_start", 32'(bus.o_tx_start), 32'd0);
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    chk("arst_done", 32'(bus.o_done), 32'd0);
    step();
    i_reset = 1'b1;
    bus.i_tx_done = 1'b1;
    step();
    bus.i_tx_done = 1'b0;
    step();
    chk("post_rst_done", 32'(bus.o_done), 32'd0);
    chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
    run_transfer(16'h0F0F, 2, 1'b0, '0, 1'b0, 1'b0, '0);

    // Back-to-back: next word offered in the o_done cycle
    run_transfer(16'h8001, 2, 1'b0, '0, 1'b0, 1'b1, 16'h7EC4);
    run_transfer(16'h7EC4, 1, 1'b0, '0, 1'b1, 1'b0, '0);

    // Randomized words, latencies and overrun injections
    for (int n = 0; n < 8; n++) begin
      w = RS'($urandom);
      run_transfer(w, int'($urandom_range(2, 6)), 1'($urandom_range(0, 1)), RS'($urandom),
                   1'b0, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
